fetch_sequencer: RTL

Control block for the fetch-stage PC register. Each cycle it picks the next PC, the PC write enable and the exception-vector request. Sources, in priority order: CP0 exception entry, `eret` return, branch/jump redirect, hazard-unit stall, sequential +4. A one-entry pending-redirect buffer keeps redirects that arrive while fetch is stalled, so they are applied once the stall releases.

---
 rtl/fetch_sequencer_pkg.sv | 15 +
 rtl/fetch_sequencer_redirect_buffer.sv | 34 +++
 rtl/fetch_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state type for the fetch-stage PC sequencer.
// Boot/vector addresses and legal instruction-memory window.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6ffc;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_sequencer_redirect_buffer.sv
// One-entry buffer for redirects that arrive while fetch is stalled.
// Clear and consume both empty it; load keeps only the newest target.
module redirect_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_target,
  input  logic        i_clear,
  input  logic        i_consume,
  output state_t      o_state,
  output logic [31:0] o_target
);

  state_t      r_state;
  logic [31:0] r_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_target <= 32'd0;
    end else if (i_clear || i_consume) begin
      r_state  <= RUN;
    end else if (i_load) begin
      r_state  <= PEND;
      r_target <= i_target;
    end
  end

  assign o_state  = r_state;
  assign o_target = r_target;

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC selection for the fetch stage: exception, eret, redirect,
// stall and sequential sources, with a stall-time redirect buffer.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = fetch_sequencer_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = fetch_sequencer_pkg::EXC_VECTOR,
  parameter logic [31:0] IM_LO      = fetch_sequencer_pkg::IM_LO,
  parameter logic [31:0] IM_HI      = fetch_sequencer_pkg::IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        req,
  output logic        flush_fd,
  output logic        pending,
  output logic        adel_f
);

  import fetch_sequencer_pkg::*;

  state_t      w_state;
  logic [31:0] w_pend_target;
  logic        w_load;
  logic [31:0] w_load_target;
  logic        w_clear;
  logic        w_consume;

  redirect_buffer u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_target  (w_load_target),
    .i_clear   (w_clear),
    .i_consume (w_consume),
    .o_state   (w_state),
    .o_target  (w_pend_target)
  );

  always_comb begin
    next_pc       = pc_f + 32'd4;
    pc_en         = 1'b1;
    req           = 1'b0;
    flush_fd      = 1'b0;
    w_load        = 1'b0;
    w_load_target = 32'd0;
    w_clear       = 1'b0;
    w_consume     = 1'b0;
    if (reset) begin
      next_pc = RESET_PC;
    end else if (exc_req) begin
      next_pc  = EXC_VECTOR;
      req      = 1'b1;
      flush_fd = 1'b1;
      w_clear  = 1'b1;
    end else if (eret) begin
      if (stall) begin
        next_pc       = pc_f;
        pc_en         = 1'b0;
        w_load        = 1'b1;
        w_load_target = epc;
      end else begin
        next_pc  = epc;
        flush_fd = 1'b1;
        w_clear  = 1'b1;
      end
    end else if (redirect_valid) begin
      if (stall) begin
        next_pc       = pc_f;
        pc_en         = 1'b0;
        w_load        = 1'b1;
        w_load_target = redirect_target;
      end else begin
        // an unstalled redirect supersedes any older buffered one
        next_pc = redirect_target;
        w_clear = 1'b1;
      end
    end else if (w_state == PEND && !stall) begin
      next_pc   = w_pend_target;
      w_consume = 1'b1;
    end else if (stall) begin
      next_pc = pc_f;
      pc_en   = 1'b0;
    end
  end

  assign pending = (w_state == PEND) && !reset;

  assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);

endmodule
